// File: rtl/rans_enc_ctrl_if.sv
// -----------------------------------------------------------------------------
// rans_enc_ctrl_if
// Bundles the job control, frequency-table, symbol-stream and encoder-side
// signals of the rANS encoder sequencer.
//   master : the sequencer (rans_enc_ctrl)
//   slave  : the environment (table source, symbol source, encoder, host)
// Job control : start_i, load_tbl_i -> busy_o, done_o, sym_cnt_o
// Table input : tbl_valid_i, tbl_freq_i, tbl_cum_freq_i -> tbl_ready_o
// Symbol input: s_valid_i, s_symb_i, s_last_i -> s_ready_o
// Encoder side: enc_ready_i -> enc_freq_wr_o, enc_restart_o, enc_en_o,
//               enc_symb_o, enc_freq_o, enc_cum_freq_o
// -----------------------------------------------------------------------------
interface rans_enc_ctrl_if #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int RESOLUTION   = 10,
   parameter int CNT_WIDTH    = 32
);
   logic                    start_i;
   logic                    load_tbl_i;
   logic                    busy_o;
   logic                    done_o;
   logic [CNT_WIDTH-1:0]    sym_cnt_o;
   logic                    tbl_valid_i;
   logic                    tbl_ready_o;
   logic [RESOLUTION-1:0]   tbl_freq_i;
   logic [RESOLUTION-1:0]   tbl_cum_freq_i;
   logic                    s_valid_i;
   logic                    s_ready_o;
   logic [SYMBOL_WIDTH-1:0] s_symb_i;
   logic                    s_last_i;
   logic                    enc_ready_i;
   logic                    enc_freq_wr_o;
   logic                    enc_restart_o;
   logic                    enc_en_o;
   logic [SYMBOL_WIDTH-1:0] enc_symb_o;
   logic [RESOLUTION-1:0]   enc_freq_o;
   logic [RESOLUTION-1:0]   enc_cum_freq_o;

   modport master (
      input  start_i, load_tbl_i, tbl_valid_i, tbl_freq_i, tbl_cum_freq_i,
             s_valid_i, s_symb_i, s_last_i, enc_ready_i,
      output busy_o, done_o, sym_cnt_o, tbl_ready_o, s_ready_o,
             enc_freq_wr_o, enc_restart_o, enc_en_o, enc_symb_o,
             enc_freq_o, enc_cum_freq_o
   );

   modport slave (
      output start_i, load_tbl_i, tbl_valid_i, tbl_freq_i, tbl_cum_freq_i,
             s_valid_i, s_symb_i, s_last_i, enc_ready_i,
      input  busy_o, done_o, sym_cnt_o, tbl_ready_o, s_ready_o,
             enc_freq_wr_o, enc_restart_o, enc_en_o, enc_symb_o,
             enc_freq_o, enc_cum_freq_o
   );
endinterface

// File: rtl/rans_enc_ctrl.sv
// -----------------------------------------------------------------------------
// rans_enc_ctrl
// Sequencer in front of a NUM_RANS-lane round-robin rANS encoder. A job
// optionally loads the whole frequency table (one entry per write, each write
// followed by a quiet window covering the encoder's busy time), restarts the
// stream, then feeds symbols so that symbol k lands on lane k mod NUM_RANS,
// and finally pulses done once the encoder pipeline has drained.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   bus          : rans_enc_ctrl_if master modport (see interface header)
// -----------------------------------------------------------------------------
module rans_enc_ctrl #(
   parameter int SYMBOL_WIDTH = 8,
   parameter int RESOLUTION   = 10,
   parameter int NUM_RANS     = 4,
   parameter int CNT_WIDTH    = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   rans_enc_ctrl_if.master bus
);
   localparam int LANE_W = $clog2(NUM_RANS);
   localparam int WAIT_W = $clog2(NUM_RANS + 3);
   localparam logic [WAIT_W-1:0] HOLD_LEN  = WAIT_W'(NUM_RANS + 1);
   localparam logic [WAIT_W-1:0] DRAIN_LEN = WAIT_W'(NUM_RANS + 2);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      HOLD    = 3'd2,
      RESTART = 3'd3,
      STREAM  = 3'd4,
      DRAIN   = 3'd5,
      DONE    = 3'd6
   } state_t;

   state_t                  state_r;
   logic [LANE_W-1:0]       slot_r;
   logic [LANE_W-1:0]       slot_next_s;
   logic [LANE_W-1:0]       lane_r;
   logic [SYMBOL_WIDTH-1:0] entry_r;
   logic [WAIT_W-1:0]       wait_r;
   logic                    last_rs_r;
   logic                    busy_r;
   logic                    done_r;
   logic                    freq_wr_r;
   logic                    restart_r;
   logic                    en_r;
   logic [CNT_WIDTH-1:0]    sym_cnt_r;
   logic [SYMBOL_WIDTH-1:0] symb_r;
   logic [RESOLUTION-1:0]   freq_r;
   logic [RESOLUTION-1:0]   cum_r;
   logic                    tbl_ready_s;
   logic                    s_ready_s;

   // A value registered now is on the enc_* pins next cycle, i.e. on lane
   // slot_r+1; a symbol is taken only when that lane is the one it owns.
   assign slot_next_s = slot_r + LANE_W'(1);
   assign tbl_ready_s = (state_r == LOAD) && bus.tbl_valid_i && bus.enc_ready_i;
   assign s_ready_s   = (state_r == STREAM) && (slot_next_s == lane_r);

   assign bus.tbl_ready_o    = tbl_ready_s;
   assign bus.s_ready_o      = s_ready_s;
   assign bus.busy_o         = busy_r;
   assign bus.done_o         = done_r;
   assign bus.sym_cnt_o      = sym_cnt_r;
   assign bus.enc_freq_wr_o  = freq_wr_r;
   assign bus.enc_restart_o  = restart_r;
   assign bus.enc_en_o       = en_r;
   assign bus.enc_symb_o     = symb_r;
   assign bus.enc_freq_o     = freq_r;
   assign bus.enc_cum_freq_o = cum_r;

   // Free-running mirror of the encoder's lane counter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slot_r <= '0;
      end else begin
         slot_r <= slot_next_s;
      end
   end

   // Job sequencer with registered strobes and status.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r   <= IDLE;
         lane_r    <= '0;
         entry_r   <= '0;
         wait_r    <= '0;
         last_rs_r <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
         freq_wr_r <= 1'b0;
         restart_r <= 1'b0;
         en_r      <= 1'b0;
         sym_cnt_r <= '0;
         symb_r    <= '0;
         freq_r    <= '0;
         cum_r     <= '0;
      end else begin
         freq_wr_r <= 1'b0;
         restart_r <= 1'b0;
         en_r      <= 1'b0;
         done_r    <= 1'b0;
         case (state_r)
            IDLE: begin
               if (bus.start_i) begin
                  sym_cnt_r <= '0;
                  lane_r    <= '0;
                  last_rs_r <= 1'b0;
                  busy_r    <= 1'b1;
                  state_r   <= bus.load_tbl_i ? LOAD : RESTART;
               end
            end
            LOAD: begin
               if (tbl_ready_s) begin
                  freq_wr_r <= 1'b1;
                  symb_r    <= entry_r;
                  freq_r    <= bus.tbl_freq_i;
                  cum_r     <= bus.tbl_cum_freq_i;
                  entry_r   <= entry_r + SYMBOL_WIDTH'(1);
                  last_rs_r <= 1'b0;
                  wait_r    <= '0;
                  state_r   <= HOLD;
               end
            end
            HOLD: begin
               // wait_r is 0 in the strobe cycle, so reaching HOLD_LEN means
               // NUM_RANS+1 strobe-free cycles have passed.
               if (wait_r == HOLD_LEN) begin
                  if (bus.enc_ready_i) begin
                     if (last_rs_r) begin
                        state_r <= STREAM;
                     end else if (entry_r == '0) begin
                        // entry index wrapped: the last entry was written
                        state_r <= RESTART;
                     end else begin
                        state_r <= LOAD;
                     end
                  end
               end else begin
                  wait_r <= wait_r + WAIT_W'(1);
               end
            end
            RESTART: begin
               if (bus.enc_ready_i) begin
                  restart_r <= 1'b1;
                  last_rs_r <= 1'b1;
                  wait_r    <= '0;
                  state_r   <= HOLD;
               end
            end
            STREAM: begin
               if (bus.s_valid_i && s_ready_s) begin
                  en_r      <= 1'b1;
                  symb_r    <= bus.s_symb_i;
                  lane_r    <= lane_r + LANE_W'(1);
                  sym_cnt_r <= sym_cnt_r + CNT_WIDTH'(1);
                  if (bus.s_last_i) begin
                     wait_r  <= '0;
                     state_r <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               // first DRAIN cycle carries the last enable; then NUM_RANS+2 quiet cycles
               if (wait_r == DRAIN_LEN) begin
                  done_r  <= 1'b1;
                  state_r <= DONE;
               end else begin
                  wait_r <= wait_r + WAIT_W'(1);
               end
            end
            DONE: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: doc/rans_enc_ctrl.md
Name: rans_enc_ctrl

Overview:
- Sequencer in front of the multi-lane rANS encoder (NUM_RANS round-robin lanes, one lane serviced per clock).
- Loads the frequency table entry by entry, respecting the encoder's NUM_RANS-cycle busy window after each write.
- Issues the stream restart, then feeds symbols so that symbol k always lands on lane k mod NUM_RANS.
- Signals completion once the encoder has drained.

Parameters:
- SYMBOL_WIDTH, 8, symbol width; the table has 2^SYMBOL_WIDTH entries.
- RESOLUTION, 10, width of freq/cum_freq values.
- NUM_RANS, 4, lane count; power of 2, ≥2.
- CNT_WIDTH, 32, width of the symbol counter.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, asynchronous active-high reset.
- start_i, in, 1, start a job; sampled in IDLE only.
- load_tbl_i, in, 1, sampled with start_i; 1 = load the table before restart.
- busy_o, out, 1, high whenever state != IDLE.
- done_o, out, 1, one-cycle pulse when the job finishes.
- sym_cnt_o, out, CNT_WIDTH, symbols accepted in the current/last job.
- tbl_valid_i, in, 1, table entry valid; entries arrive in symbol order 0..2^SW-1.
- tbl_ready_o, out, 1, table entry accepted (combinational).
- tbl_freq_i, in, RESOLUTION, table frequency.
- tbl_cum_freq_i, in, RESOLUTION, table cumulative frequency.
- s_valid_i, in, 1, input symbol valid.
- s_ready_o, out, 1, input symbol accepted (combinational).
- s_symb_i, in, SYMBOL_WIDTH, input symbol.
- s_last_i, in, 1, marks the final symbol of the job.
- enc_ready_i, in, 1, encoder ready.
- enc_freq_wr_o, out, 1, registered; encoder frequency-table write strobe.
- enc_restart_o, out, 1, registered; encoder restart strobe.
- enc_en_o, out, 1, registered; encoder symbol enable.
- enc_symb_o, out, SYMBOL_WIDTH, registered; doubles as the frequency write address.
- enc_freq_o, out, RESOLUTION, registered.
- enc_cum_freq_o, out, RESOLUTION, registered.

Behaviour:
- Reset: state=IDLE; all enc_* outputs=0; done_o=0; busy_o=0; sym_cnt_o=0; slot_r=0; lane_r=0; entry counter=0. A reset mid-job aborts immediately with no further strobes.
- slot_r:
  - log2(NUM_RANS)-bit counter, increments every cycle, never stalls.
  - Mirrors the encoder's lane counter; both are reset by the same rst_i.
  - A value driven on enc_* in cycle c targets lane slot_r(c).
- States: IDLE, LOAD, HOLD, RESTART, STREAM, DRAIN, DONE.
- IDLE:
  - start_i=1 → LOAD if load_tbl_i=1, else RESTART.
  - On start_i, clear sym_cnt_o and lane_r.
- LOAD:
  - When tbl_valid_i && enc_ready_i, assert tbl_ready_o.
  - Next cycle: enc_freq_wr_o=1 for one cycle, enc_symb_o=entry index, enc_freq_o/enc_cum_freq_o=the entry.
  - Increment the entry index, then go to HOLD.
- HOLD:
  - Wait NUM_RANS+1 cycles with no strobes, then require enc_ready_i=1 before leaving.
  - Exit to LOAD if entries remain.
  - Exit to RESTART if the last entry (index 2^SW-1) was written.
  - Exit to STREAM if the last pulse was a restart.
  - The entry index wraps to 0 after the last entry.
- RESTART: with enc_ready_i=1, drive enc_restart_o=1 for one cycle, then go to HOLD.
- STREAM:
  - s_ready_o = s_valid_i-independent: 1 iff (slot_r+1) mod NUM_RANS == lane_r.
  - On accept (s_valid_i && s_ready_o): next cycle enc_en_o=1 and enc_symb_o=s_symb_i; lane_r++ (mod NUM_RANS); sym_cnt_o++ (wraps at 2^CNT_WIDTH).
  - Otherwise enc_en_o=0 next cycle.
  - An upstream bubble costs a full NUM_RANS-cycle revolution; lane assignment is never skipped.
  - Accepting with s_last_i=1 → DRAIN.
- DRAIN: wait NUM_RANS+2 cycles with enc_en_o=0, then → DONE.
- DONE: done_o=1 for one cycle → IDLE.
- Ignored inputs: start_i while busy is ignored. tbl_valid_i outside LOAD and s_valid_i outside STREAM are never acknowledged.
- Strobe exclusivity: at most one of enc_freq_wr_o, enc_restart_o, enc_en_o is high in any cycle.

Test Plan:
- Load job, NUM_RANS=4, 256 entries with freq=4, cum=4·i:
  - exactly 256 enc_freq_wr_o pulses with addresses 0..255 in order, consecutive pulses ≥6 cycles apart;
  - then one enc_restart_o pulse;
  - no strobe while enc_ready_i=0.
- No-load job, 8 back-to-back symbols 0x10..0x17 (last on 0x17):
  - no freq writes;
  - each enc_en_o lands on slot_r = 0,1,2,3,0,1,2,3;
  - sym_cnt_o=8;
  - done_o pulses exactly NUM_RANS+2+1 cycles after the last enc_en_o.
- Bubble on symbol 2 (s_valid_i low for 1 cycle): symbol 2 still lands on slot 2, four cycles later than in the gapless case; symbol 3 lands on slot 3.
- start_i pulsed during STREAM: ignored; the job completes normally and done_o pulses once.
- rst_i asserted mid-LOAD after 10 entries:
  - all outputs go to 0 asynchronously;
  - a new load job rewrites from address 0.
- Single symbol with s_last_i=1: sym_cnt_o=1, one enc_en_o pulse, done_o pulses, busy_o then low.
